gradient_accumulator: RTL and testbench
=======================================

Name: gradient_accumulator

Overview:
Receiving end of the backprop path of a learning neuron. Accepts per-input backprop delta vectors once per training sample and accumulates them per lane over an epoch. At epoch end it emits one scaled, saturated weight-update vector through a valid/ready handshake. It sits between a neuron's back[] output and the weight-update logic, and uses signed fixed point in place of real.

Parameters:
- N_INPUTS, 32, number of lanes; matches the neuron input and enable vector width.
- WIDTH, 16, signed delta and update width, Q8.8 (1.0 = 0x0100).
- ACC_WIDTH, 24, signed per-lane accumulator width; must be at least WIDTH.
- LR_SHIFT, 2, learning-rate scaling; update = acc >>> LR_SHIFT.
- CNT_WIDTH, 16, width of the sample counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- delta_valid  in  1  delta_in holds a sample.
- delta_ready  out  1  block accepts a sample this cycle.
- delta_in  in  N_INPUTS*WIDTH  packed deltas; lane i is bits [i*WIDTH +: WIDTH].
- enabled  in  N_INPUTS  lane mask; a lane accumulates only when its bit is 1.
- epoch_end  in  1  one-cycle pulse that closes the epoch.
- update_valid  out  1  update_out, epoch_samples and overflow are valid.
- update_ready  in  1  downstream consumes the update.
- update_out  out  N_INPUTS*WIDTH  packed scaled updates.
- epoch_samples  out  CNT_WIDTH  number of samples accepted in the epoch.
- overflow  out  1  at least one accumulator saturated during the epoch.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high and is named reset.
- Reset values: state ACCUM, all accumulators 0, sample count 0, update_out 0, update_valid 0, overflow 0, delta_ready 1.
- Reset takes effect in any state, including mid-DRAIN and in PRESENT. A partial epoch is discarded.
- States: ACCUM, DRAIN, PRESENT.
- ACCUM, sample handling:
  - delta_ready = 1.
  - On delta_valid, each lane i with enabled[i]=1 does acc[i] <= sat_ACC(acc[i] + sign-extended delta_in lane i).
  - Disabled lanes hold their value.
  - The sample count increments and saturates at all-ones.
- ACCUM, saturation: when an add would exceed the ACC_WIDTH range, the accumulator clamps to max or min and overflow sets. overflow is sticky until the update handshake.
- ACCUM, epoch_end:
  - epoch_end together with delta_valid: the sample is accumulated first, then the state moves to DRAIN.
  - epoch_end with zero accumulated samples and no concurrent sample is ignored; the state stays ACCUM.
- epoch_end in DRAIN or PRESENT is ignored.
- DRAIN:
  - delta_ready = 0; delta_valid is ignored.
  - One lane per cycle, lane 0 to N_INPUTS-1.
  - update lane = sat_WIDTH(acc >>> LR_SHIFT), using arithmetic shift, i.e. floor toward minus infinity.
  - The accumulator of that lane clears to 0.
  - Saturating the shifted value to WIDTH does not set overflow.
  - After the last lane, the state moves to PRESENT.
- Latency: epoch_end accepted at edge T gives update_valid = 1 after edge T+N_INPUTS+1.
- PRESENT:
  - update_valid = 1, and update_out, epoch_samples and overflow are held stable.
  - delta_ready = 0.
  - On update_valid && update_ready at an edge: update_valid falls, the sample count and overflow clear, and the state returns to ACCUM. delta_ready is 1 in the following cycle.
  - update_out keeps its last value after the handshake until the next DRAIN overwrites it.
- Sign extension of delta_in to ACC_WIDTH is mandatory.

Decomposition:
- Package neuron_fx_pkg holds:
  - WIDTH and FRAC constants.
  - typedef fx_t (signed WIDTH) and acc_t (signed ACC_WIDTH).
  - state enum {ACCUM, DRAIN, PRESENT}.
  - functions sat_acc() and sat_fx().
- One sub-module, fx_shift_sat: combinational arithmetic shift by LR_SHIFT followed by saturation to WIDTH. It is used once, in the DRAIN lane path.

Test Plan:
- Basic epoch: reset; enabled=0x3; 4 samples with lane0=0x0100 and lane1=0xFF00; epoch_end on the 4th -> update_valid after 33 cycles; lane0=0x0100, lane1=0xFF00, other lanes 0; epoch_samples=4; overflow=0.
- Masking: enabled=0x1; 3 samples with lane1=0x0100 -> lane1 update 0x0000; lane0 accumulates normally.
- Saturation: 300 samples with lane0=0x7FFF -> acc clamps at 0x7FFFFF; overflow=1; lane0 update 0x7FFF; overflow clears after the handshake.
- Backpressure: hold update_ready=0 for 10 cycles in PRESENT while driving delta_valid=1 -> update_valid and update_out stable, delta_ready=0, no accumulation; after the handshake, the next epoch of 1 sample at 0x0100 gives lane0 update 0x0040.
- Rounding: single sample lane0=0xFFFF, LR_SHIFT=2 -> lane0 update 0xFFFF (floor of -1/4).
- Boundary events:
  - epoch_end with 0 samples -> no state change.
  - reset asserted on DRAIN cycle 5 -> next cycle all outputs at reset values; the following epoch of one sample with lane0=0x0100 gives lane0 update 0x0040, so no residue from the aborted epoch remains.

Source files
------------

// File: rtl/neuron_fx_pkg.sv
// Fixed-point types, FSM states and saturation helpers shared by the neuron
// backprop datapath.
//
// Contents:
//   WIDTH / FRAC / ACC_WIDTH : Q8.8 sample format and per-lane accumulator width
//   fx_t / acc_t             : signed sample and accumulator types
//   state_e                  : gradient accumulator states
//   sat_acc / acc_sum_ovf    : clamp an (ACC_WIDTH+1)-bit sum into acc_t
//   sat_fx                   : clamp an accumulator-width value into fx_t
package neuron_fx_pkg;

  localparam int WIDTH     = 16;
  localparam int FRAC      = 8;
  localparam int ACC_WIDTH = 24;

  typedef logic signed [WIDTH-1:0]     fx_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    PRESENT
  } state_e;

  localparam fx_t  FX_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam fx_t  FX_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam fx_t  FX_ONE  = fx_t'(1 << FRAC);
  localparam acc_t ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // fx_t limits widened (sign-extended) to accumulator width for comparison.
  localparam acc_t ACC_FX_MAX = acc_t'(FX_MAX);
  localparam acc_t ACC_FX_MIN = acc_t'(FX_MIN);

  // A sum one bit wider than the accumulator left the acc_t range exactly
  // when its top two bits disagree.
  function automatic logic acc_sum_ovf(input logic signed [ACC_WIDTH:0] s);
    return s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
  endfunction

  function automatic acc_t sat_acc(input logic signed [ACC_WIDTH:0] s);
    if (acc_sum_ovf(s)) begin
      return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    return s[ACC_WIDTH-1:0];
  endfunction

  function automatic fx_t sat_fx(input acc_t v);
    if (v > ACC_FX_MAX) begin
      return FX_MAX;
    end
    if (v < ACC_FX_MIN) begin
      return FX_MIN;
    end
    return v[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fx_shift_sat.sv
// Learning-rate scaling for one drained lane: arithmetic right shift of an
// accumulator by LR_SHIFT (floor toward minus infinity) followed by
// saturation to the Q8.8 update width. Purely combinational.
//
// Ports:
//   acc_in   in  ACC_WIDTH  signed accumulator value
//   upd_out  out WIDTH      signed, scaled and saturated update
module fx_shift_sat
  import neuron_fx_pkg::*;
#(
  parameter int LR_SHIFT = 2
) (
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic signed [WIDTH-1:0]     upd_out
);

  acc_t shifted;

  // acc_in is signed, so >>> replicates the sign bit (floor, not truncation
  // toward zero): -1 >>> 2 stays -1.
  assign shifted = acc_in >>> LR_SHIFT;
  assign upd_out = sat_fx(shifted);

endmodule

// File: rtl/gradient_accumulator.sv
// Gradient accumulator: receiving end of a neuron's backprop path.
//
// During an epoch each accepted delta vector is added, lane by lane, into a
// saturating signed accumulator (masked by enabled). epoch_end closes the
// epoch; the block then drains one lane per cycle through fx_shift_sat into
// the update register, clearing each accumulator as it goes, and finally
// presents the update vector until downstream takes it.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   delta_valid    in   delta_in holds a sample
//   delta_ready    out  sample accepted this cycle (ACCUM only)
//   delta_in       in   N_INPUTS packed Q8.8 deltas, lane i at [i*WIDTH +: WIDTH]
//   enabled        in   per-lane accumulate mask
//   epoch_end      in   one-cycle pulse closing the epoch
//   update_valid   out  update_out / epoch_samples / overflow valid
//   update_ready   in   downstream consumes the update
//   update_out     out  N_INPUTS packed scaled, saturated updates
//   epoch_samples  out  samples accepted in the epoch (saturating)
//   overflow       out  some accumulator clamped during the epoch
module gradient_accumulator
  import neuron_fx_pkg::*;
#(
  parameter int N_INPUTS  = 32,
  parameter int WIDTH     = neuron_fx_pkg::WIDTH,
  parameter int ACC_WIDTH = neuron_fx_pkg::ACC_WIDTH,
  parameter int LR_SHIFT  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      delta_valid,
  output logic                      delta_ready,
  input  logic [N_INPUTS*WIDTH-1:0] delta_in,
  input  logic [N_INPUTS-1:0]       enabled,
  input  logic                      epoch_end,
  output logic                      update_valid,
  input  logic                      update_ready,
  output logic [N_INPUTS*WIDTH-1:0] update_out,
  output logic [CNT_WIDTH-1:0]      epoch_samples,
  output logic                      overflow
);

  localparam int LANE_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  // Drain counter also has to hold N_INPUTS itself (the trailing cycle).
  localparam int LCNT_W = $clog2(N_INPUTS + 1);

  state_e                    state_q, state_d;
  acc_t                      acc_q [N_INPUTS];
  acc_t                      acc_d [N_INPUTS];
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic [LCNT_W-1:0]         lane_q, lane_d;
  logic [N_INPUTS*WIDTH-1:0] upd_q, upd_d;

  logic signed [ACC_WIDTH:0] lane_sum [N_INPUTS];
  logic [LANE_W-1:0]         drain_idx;
  acc_t                      drain_acc;
  fx_t                       drain_upd;

  // ---------------------------------------------------------------------------
  // Per-lane adders: one extra bit of headroom so the true sum is available
  // for saturation. Both operands are sign-extended explicitly.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      lane_sum[i] = {acc_q[i][ACC_WIDTH-1], acc_q[i]}
                  + {{(ACC_WIDTH+1-WIDTH){delta_in[i*WIDTH+WIDTH-1]}},
                     delta_in[i*WIDTH +: WIDTH]};
    end
  end

  // ---------------------------------------------------------------------------
  // Drain lane path: the lane under lane_q is scaled and saturated.
  // ---------------------------------------------------------------------------
  assign drain_idx = lane_q[LANE_W-1:0];
  assign drain_acc = acc_q[drain_idx];

  fx_shift_sat #(
    .LR_SHIFT (LR_SHIFT)
  ) u_shift_sat (
    .acc_in  (drain_acc),
    .upd_out (drain_upd)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  // NOTE: every *_d gets a default before the case so no path leaves a
  // variable unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    lane_d  = lane_q;
    upd_d   = upd_q;

    unique case (state_q)
      ACCUM: begin
        if (delta_valid) begin
          for (int i = 0; i < N_INPUTS; i++) begin
            if (enabled[i]) begin
              acc_d[i] = sat_acc(lane_sum[i]);
              if (acc_sum_ovf(lane_sum[i])) begin
                ovf_d = 1'b1;
              end
            end
          end
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        // An empty epoch (nothing accumulated, no sample arriving with the
        // pulse) has nothing to report, so the pulse is dropped.
        if (epoch_end && (delta_valid || cnt_q != '0)) begin
          state_d = DRAIN;
          lane_d  = '0;
        end
      end

      DRAIN: begin
        // Lanes 0..N_INPUTS-1 are written on successive cycles; one trailing
        // cycle (lane_q == N_INPUTS) performs no lane work and hands over to
        // PRESENT, giving N_INPUTS+1 cycles from epoch_end to update_valid.
        if (lane_q == LCNT_W'(N_INPUTS)) begin
          state_d = PRESENT;
        end else begin
          upd_d[drain_idx*WIDTH +: WIDTH] = drain_upd;
          acc_d[drain_idx]                = '0;
          lane_d                          = lane_q + LCNT_W'(1);
        end
      end

      PRESENT: begin
        if (update_ready) begin
          state_d = ACCUM;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      // NOTE: the accumulator array is reset, unlike a plain storage memory,
      // because a reset mid-epoch must not leak partial sums into the next.
      for (int i = 0; i < N_INPUTS; i++) begin
        acc_q[i] <= '0;
      end
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      lane_q  <= '0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < N_INPUTS; i++) begin
        acc_q[i] <= acc_d[i];
      end
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      lane_q  <= lane_d;
      upd_q   <= upd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from or driven directly by registers.
  // ---------------------------------------------------------------------------
  assign delta_ready   = (state_q == ACCUM);
  assign update_valid  = (state_q == PRESENT);
  assign update_out    = upd_q;
  assign epoch_samples = cnt_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_gradient_accumulator.sv
// Directed bench for gradient_accumulator. Inputs change and outputs are
// sampled just after the falling edge, away from the active rising edge.
module tb_gradient_accumulator;
  import neuron_fx_pkg::*;

  localparam int N  = 32;
  localparam int W  = 16;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           delta_valid;
  logic           delta_ready;
  logic [N*W-1:0] delta_in;
  logic [N-1:0]   enabled;
  logic           epoch_end;
  logic           update_valid;
  logic           update_ready;
  logic [N*W-1:0] update_out;
  logic [CW-1:0]  epoch_samples;
  logic           overflow;

  int vectors     = 0;
  int miscompares = 0;

  gradient_accumulator #(
    .N_INPUTS  (N),
    .WIDTH     (W),
    .ACC_WIDTH (24),
    .LR_SHIFT  (2),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .delta_valid   (delta_valid),
    .delta_ready   (delta_ready),
    .delta_in      (delta_in),
    .enabled       (enabled),
    .epoch_end     (epoch_end),
    .update_valid  (update_valid),
    .update_ready  (update_ready),
    .update_out    (update_out),
    .epoch_samples (epoch_samples),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input int i);
    return update_out[i*W +: W];
  endfunction

  task automatic fill(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) delta_in[i*W +: W] = v;
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] v);
    delta_in[i*W +: W] = v;
  endtask

  // One sample presented for one rising edge; optional epoch_end with it.
  task automatic send(input logic eoe);
    delta_valid = 1'b1;
    epoch_end   = eoe;
    @(negedge clk);
    delta_valid = 1'b0;
    epoch_end   = 1'b0;
  endtask

  // Called at the falling edge just after epoch_end was taken; counts edges
  // until update_valid, bounded.
  task automatic wait_update(input string tag);
    int n = 0;
    while (update_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, 33);
  endtask

  task automatic handshake(input string tag);
    update_ready = 1'b1;
    @(negedge clk);
    update_ready = 1'b0;
    chk({tag, "_valid_low"}, update_valid, 0);
    chk({tag, "_ready_high"}, delta_ready, 1);
    chk({tag, "_samples_clr"}, epoch_samples, 0);
    chk({tag, "_ovf_clr"}, overflow, 0);
  endtask

  initial begin
    reset        = 1'b1;
    delta_valid  = 1'b0;
    epoch_end    = 1'b0;
    update_ready = 1'b0;
    enabled      = '0;
    delta_in     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_delta_ready", delta_ready, 1);
    chk("rst_update_valid", update_valid, 0);
    chk("rst_update_out", {31'd0, |update_out}, 0);
    chk("rst_samples", epoch_samples, 0);
    chk("rst_overflow", overflow, 0);

    // Basic epoch: 4 x (+1.0, -1.0) -> acc +/-4.0 -> update +/-1.0
    enabled = 32'h3;
    fill(16'h0000);
    set_lane(0, FX_ONE);
    set_lane(1, 16'hFF00);
    repeat (3) send(1'b0);
    send(1'b1);
    wait_update("basic_latency");
    chk("basic_lane0", lane(0), 16'h0100);
    chk("basic_lane1", lane(1), 16'hFF00);
    chk("basic_lane2", lane(2), 16'h0000);
    chk("basic_lane31", lane(31), 16'h0000);
    chk("basic_samples", epoch_samples, 4);
    chk("basic_overflow", overflow, 0);
    handshake("basic_hs");

    // Masking: lane1 disabled; epoch_end on its own after 3 samples
    enabled = 32'h1;
    set_lane(0, FX_ONE);
    set_lane(1, FX_ONE);
    repeat (3) send(1'b0);
    epoch_end = 1'b1;
    @(negedge clk);
    epoch_end = 1'b0;
    wait_update("mask_latency");
    chk("mask_lane0", lane(0), 16'h00C0);
    chk("mask_lane1", lane(1), 16'h0000);
    chk("mask_samples", epoch_samples, 3);
    handshake("mask_hs");

    // Rounding: -1 LSB >>> 2 floors to -1 LSB
    fill(16'h0000);
    set_lane(0, 16'hFFFF);
    send(1'b1);
    wait_update("round_latency");
    chk("round_lane0", lane(0), 16'hFFFF);
    chk("round_samples", epoch_samples, 1);
    handshake("round_hs");

    // epoch_end with no samples is ignored
    epoch_end = 1'b1;
    @(negedge clk);
    epoch_end = 1'b0;
    chk("empty_eoe_ready", delta_ready, 1);
    repeat (40) @(negedge clk);
    chk("empty_eoe_no_valid", update_valid, 0);
    chk("empty_eoe_samples", epoch_samples, 0);

    // Saturation: 256 x 0x7FFF fits (0x7FFF00), the 257th clamps
    set_lane(0, 16'h7FFF);
    repeat (256) send(1'b0);
    chk("sat_no_ovf_256", overflow, 0);
    send(1'b0);
    chk("sat_ovf_257", overflow, 1);
    repeat (42) send(1'b0);
    send(1'b1);
    wait_update("sat_latency");
    chk("sat_lane0", lane(0), 16'h7FFF);
    chk("sat_samples", epoch_samples, 300);
    chk("sat_overflow", overflow, 1);

    // Backpressure in PRESENT with delta_valid and epoch_end held high
    set_lane(0, FX_ONE);
    delta_valid = 1'b1;
    epoch_end   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", update_valid, 1);
      chk("bp_lane0", lane(0), 16'h7FFF);
      chk("bp_ready", delta_ready, 0);
      chk("bp_samples", epoch_samples, 300);
    end
    delta_valid = 1'b0;
    epoch_end   = 1'b0;
    handshake("bp_hs");
    chk("bp_out_held", lane(0), 16'h7FFF);
    send(1'b1);
    wait_update("bp_next_latency");
    chk("bp_next_lane0", lane(0), 16'h0040);
    chk("bp_next_samples", epoch_samples, 1);
    chk("bp_next_overflow", overflow, 0);
    handshake("bp_next_hs");

    // Reset on DRAIN cycle 5 discards the epoch
    enabled = '1;
    fill(FX_ONE);
    repeat (2) send(1'b0);
    send(1'b1);
    repeat (4) @(negedge clk);
    chk("abort_in_drain", delta_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", delta_ready, 1);
    chk("abort_valid", update_valid, 0);
    chk("abort_out", {31'd0, |update_out}, 0);
    chk("abort_samples", epoch_samples, 0);
    chk("abort_overflow", overflow, 0);
    send(1'b1);
    wait_update("abort_next_latency");
    chk("abort_next_lane0", lane(0), 16'h0040);
    chk("abort_next_lane20", lane(20), 16'h0040);
    chk("abort_next_samples", epoch_samples, 1);
    enabled = 32'h1;
    handshake("abort_next_hs");
    send(1'b1);
    wait_update("residue_latency");
    chk("residue_lane0", lane(0), 16'h0040);
    chk("residue_lane20", lane(20), 16'h0000);
    handshake("residue_hs");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
